// File: rtl/sargantana_icache_pkg.sv
// Shared instruction-cache geometry and flush controller state encoding.
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_DEPTH = 64;
    localparam int unsigned ICACHE_WAYS  = 4;
    localparam int unsigned IDX_W        = $clog2(ICACHE_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } flush_state_t;

endpackage

// File: rtl/sargantana_icache_flush_ctrl.sv
// Instruction-cache flush controller: drains refills, sweeps every set clearing
// all ways, then acks.
module sargantana_icache_flush_ctrl
    import sargantana_icache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_req_i,
    input  logic                   refill_busy_i,
    output logic                   sweep_en_o,
    input  logic [IDX_W-1:0]       sweep_idx_i,
    input  logic                   sweep_done_i,
    output logic                   inval_we_o,
    output logic [IDX_W-1:0]       inval_idx_o,
    output logic [ICACHE_WAYS-1:0] inval_way_o,
    output logic                   fetch_stall_o,
    output logic                   flush_ack_o
);

    flush_state_t state_q, state_d;
    logic         pend_q, pend_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // A request during SWEEP cannot restart the sweep in place, so it is
    // remembered and replayed as one more full pass after DONE.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!refill_busy_i) state_d = SWEEP;
            end
            SWEEP: begin
                if (flush_req_i)  pend_d  = 1'b1;
                if (sweep_done_i) state_d = DONE;
            end
            DONE: begin
                pend_d  = 1'b0;
                state_d = (pend_q || flush_req_i) ? DRAIN : IDLE;
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign sweep_en_o    = (state_q == SWEEP);
    assign inval_we_o    = (state_q == SWEEP);
    assign inval_idx_o   = inval_we_o ? sweep_idx_i : '0;
    assign inval_way_o   = {ICACHE_WAYS{inval_we_o}};
    assign fetch_stall_o = (state_q != IDLE);
    assign flush_ack_o   = (state_q == DONE);

`ifndef SYNTHESIS
    // Sweep counter and miss unit handshake checks.
    a_no_refill_in_sweep: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (state_q == SWEEP) |-> !refill_busy_i);

    a_done_needs_en: assert property (@(posedge clk_i) disable iff (!rstn_i)
        sweep_done_i |-> sweep_en_o);

    a_done_at_last_set: assert property (@(posedge clk_i) disable iff (!rstn_i)
        sweep_done_i |-> (sweep_idx_i == IDX_W'(ICACHE_DEPTH - 1)));

    a_sweep_starts_at_zero: assert property (@(posedge clk_i) disable iff (!rstn_i)
        ((state_q == SWEEP) && ($past(state_q) != SWEEP)) |-> (sweep_idx_i == '0));

    a_sweep_idx_steps: assert property (@(posedge clk_i) disable iff (!rstn_i)
        ((state_q == SWEEP) && ($past(state_q) == SWEEP))
            |-> (sweep_idx_i == IDX_W'($past(sweep_idx_i) + 1'b1)));
`endif

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Bench for the icache flush controller with sweep counter and valid-array models.
module tb_sargantana_icache_flush_ctrl;
    import sargantana_icache_pkg::*;

    localparam int DEPTH    = int'(ICACHE_DEPTH);
    localparam int ALL_WAYS = (1 << ICACHE_WAYS) - 1;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   flush_req = 1'b0;
    logic                   refill_busy = 1'b0;
    logic                   spurious_done = 1'b0;
    logic                   fill_req = 1'b0;
    logic                   sweep_en;
    logic [IDX_W-1:0]       sweep_idx;
    logic                   sweep_done;
    logic                   inval_we;
    logic [IDX_W-1:0]       inval_idx;
    logic [ICACHE_WAYS-1:0] inval_way;
    logic                   fetch_stall;
    logic                   flush_ack;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int clears = 0;
    int sweep_start = -1;
    logic prev_en = 1'b0;
    int ack_q[$];

    sargantana_icache_flush_ctrl dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .flush_req_i   (flush_req),
        .refill_busy_i (refill_busy),
        .sweep_en_o    (sweep_en),
        .sweep_idx_i   (sweep_idx),
        .sweep_done_i  (sweep_done),
        .inval_we_o    (inval_we),
        .inval_idx_o   (inval_idx),
        .inval_way_o   (inval_way),
        .fetch_stall_o (fetch_stall),
        .flush_ack_o   (flush_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sibling sweep counter: advances while enabled, wraps after the last set.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)         sweep_idx <= '0;
        else if (sweep_en) sweep_idx <= (sweep_idx == IDX_W'(DEPTH - 1)) ? '0 : IDX_W'(sweep_idx + 1'b1);
    end
    assign sweep_done = (sweep_idx == IDX_W'(DEPTH - 1)) | spurious_done;

    logic [ICACHE_WAYS-1:0] valid [ICACHE_DEPTH];
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < DEPTH; i++) valid[i] <= '1;
        end else if (rstn && inval_we) begin
            valid[inval_idx] <= valid[inval_idx] & ~inval_way;
        end
    end

    // Flush timeline model: -1 idle, 0 waiting for refills, 1..DEPTH sweeping set pos-1,
    // DEPTH+1 ack cycle.
    int m_pos  = -1;
    int m_owed = 0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pos  = -1;
            m_owed = 0;
        end else if (m_pos < 0) begin
            if (flush_req) m_pos = 0;
        end else if (m_pos == 0) begin
            if (!refill_busy) m_pos = 1;
        end else if (m_pos <= DEPTH) begin
            if (flush_req) m_owed = 1;
            m_pos = m_pos + 1;
        end else begin
            m_pos  = (m_owed != 0 || flush_req) ? 0 : -1;
            m_owed = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit sw;
        sw = (m_pos >= 1) && (m_pos <= DEPTH);
        chk("cyc_stall",     int'(fetch_stall), int'(m_pos >= 0));
        chk("cyc_sweep_en",  int'(sweep_en),    int'(sw));
        chk("cyc_inval_we",  int'(inval_we),    int'(sw));
        chk("cyc_inval_idx", int'(inval_idx),   sw ? m_pos - 1 : 0);
        chk("cyc_inval_way", int'(inval_way),   sw ? ALL_WAYS : 0);
        chk("cyc_ack",       int'(flush_ack),   int'(m_pos == DEPTH + 1));
        if (inval_we) clears++;
        if (flush_ack) ack_q.push_back(cyc);
        if (sweep_en && !prev_en) sweep_start = cyc;
        prev_en = sweep_en;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    function automatic int valid_ones();
        int s = 0;
        for (int i = 0; i < DEPTH; i++)
            for (int w = 0; w < int'(ICACHE_WAYS); w++) s += int'(valid[i][w]);
        return s;
    endfunction

    task automatic wait_acks(input string name, input int target, input int budget);
        int n = 0;
        while (ack_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, ack_q.size(), target);
    endtask

    task automatic wait_idx(input string name, input int target);
        int n = 0;
        while (!(sweep_en && inval_idx == IDX_W'(target)) && n < 200) begin
            tick();
            n++;
        end
        chk(name, int'(inval_idx), target);
    endtask

    task automatic pulse_req();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, a0, c0;

        // Reset state
        repeat (3) tick();
        chk("rst_stall", int'(fetch_stall), 0);
        chk("rst_ack",   int'(flush_ack),   0);
        chk("rst_we",    int'(inval_we),    0);
        chk("rst_en",    int'(sweep_en),    0);
        rstn = 1'b1;
        tick();

        // 1: single pulse, no refill
        fill();
        t0 = cyc; a0 = ack_q.size(); c0 = clears;
        pulse_req();
        chk("t1_stall_c1", int'(fetch_stall), 1);
        chk("t1_en_c1",    int'(sweep_en),    0);
        wait_acks("t1_ack_seen", a0 + 1, 100);
        chk("t1_ack_cyc",     ack_q[a0] - t0, 66);
        chk("t1_sweep_start", sweep_start - t0, 2);
        tick();
        chk("t1_clears",   clears - c0, 64);
        chk("t1_valid",    valid_ones(), 0);
        chk("t1_idle",     int'(fetch_stall), 0);

        // 2: refill busy for 10 cycles after the request
        fill();
        t0 = cyc; a0 = ack_q.size(); c0 = clears;
        flush_req = 1'b1;
        refill_busy = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t2_no_sweep", int'(sweep_en), 0);
            tick();
        end
        refill_busy = 1'b0;
        wait_acks("t2_ack_seen", a0 + 1, 100);
        chk("t2_sweep_start", sweep_start - t0, 12);
        chk("t2_ack_cyc",     ack_q[a0] - t0, 76);
        repeat (5) tick();
        chk("t2_one_ack", ack_q.size(), a0 + 1);
        chk("t2_clears",  clears - c0, 64);
        chk("t2_valid",   valid_ones(), 0);

        // 3a: second request while draining merges
        fill();
        t0 = cyc; a0 = ack_q.size(); c0 = clears;
        flush_req = 1'b1;
        tick();
        tick();
        flush_req = 1'b0;
        wait_acks("t3a_ack_seen", a0 + 1, 100);
        chk("t3a_ack_cyc", ack_q[a0] - t0, 66);
        repeat (80) tick();
        chk("t3a_one_ack", ack_q.size(), a0 + 1);
        chk("t3a_clears",  clears - c0, 64);
        chk("t3a_valid",   valid_ones(), 0);

        // 3b: second request mid-sweep forces another full sweep
        fill();
        t0 = cyc; a0 = ack_q.size(); c0 = clears;
        pulse_req();
        wait_idx("t3b_reach_30", 30);
        pulse_req();
        wait_acks("t3b_acks_seen", a0 + 2, 250);
        chk("t3b_ack1_cyc", ack_q[a0] - t0, 66);
        chk("t3b_ack_gap",  ack_q[a0 + 1] - ack_q[a0], 66);
        repeat (5) tick();
        chk("t3b_two_acks", ack_q.size(), a0 + 2);
        chk("t3b_clears",   clears - c0, 128);
        chk("t3b_valid",    valid_ones(), 0);

        // 4: reset mid-sweep abandons it; next flush starts from set 0
        fill();
        a0 = ack_q.size();
        pulse_req();
        wait_idx("t4_reach_20", 20);
        rstn = 1'b0;
        #1;
        chk("t4_rst_stall", int'(fetch_stall), 0);
        chk("t4_rst_en",    int'(sweep_en),    0);
        chk("t4_rst_we",    int'(inval_we),    0);
        chk("t4_rst_idx",   int'(inval_idx),   0);
        chk("t4_rst_way",   int'(inval_way),   0);
        chk("t4_rst_ack",   int'(flush_ack),   0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        chk("t4_no_ack",      ack_q.size(), a0);
        chk("t4_partial_val", valid_ones(), (64 - 20) * 4);
        t0 = cyc; c0 = clears;
        pulse_req();
        wait_acks("t4_ack_seen", a0 + 1, 100);
        chk("t4_ack_cyc", ack_q[a0] - t0, 66);
        tick();
        chk("t4_clears", clears - c0, 64);
        chk("t4_valid",  valid_ones(), 0);

        // 5: request held 200 cycles gives back-to-back sweeps
        t0 = cyc; a0 = ack_q.size();
        flush_req = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            chk("t5_stall_held", int'(fetch_stall), 1);
        end
        flush_req = 1'b0;
        wait_acks("t5_acks_seen", a0 + 4, 120);
        chk("t5_ack1_cyc", ack_q[a0] - t0, 66);
        chk("t5_gap1",     ack_q[a0 + 1] - ack_q[a0], 66);
        chk("t5_gap2",     ack_q[a0 + 2] - ack_q[a0 + 1], 66);
        chk("t5_ack4_cyc", ack_q[a0 + 3] - t0, 264);
        repeat (5) tick();
        chk("t5_four_acks", ack_q.size(), a0 + 4);
        chk("t5_idle",      int'(fetch_stall), 0);

        // 6: spurious sweep_done while idle is ignored
        $assertoff;
        a0 = ack_q.size();
        spurious_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stall", int'(fetch_stall), 0);
            chk("t6_en",    int'(sweep_en),    0);
            chk("t6_ack",   int'(flush_ack),   0);
        end
        spurious_done = 1'b0;
        tick();
        $asserton;
        chk("t6_no_ack", ack_q.size(), a0);
        t0 = cyc;
        pulse_req();
        wait_acks("t6_ack_seen", a0 + 1, 100);
        chk("t6_ack_cyc", ack_q[a0] - t0, 66);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
